secure_mem_access_ctrl: RTL and testbench

//  Access-control front end directly upstream of the MCSE secure memory; sole master of its rd_en/wr_en/addr/wrData port.

---
 rtl/secure_mem_access_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_secure_mem_access_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secure_mem_access_ctrl.sv
// secure_mem_access_ctrl
// Access-control front end for the MCSE secure memory. Accepts one request at
// a time, checks it against the per-address lifecycle policy, drives the
// memory port and returns read data or a status code on a valid/ready channel.
// Optional violation logging is enabled by defining SECMEM_ACCESS_LOG_EN.

`ifndef SECURE_MEMORY_WIDTH
`define SECURE_MEMORY_WIDTH 64
`endif
`ifndef SECURE_MEMORY_LENGTH
`define SECURE_MEMORY_LENGTH 16
`endif

module secure_mem_access_ctrl #(
    parameter int unsigned WIDTH   = `SECURE_MEMORY_WIDTH,
    parameter int unsigned LENGTH  = `SECURE_MEMORY_LENGTH,
    parameter int unsigned TIMEOUT = 16,
    localparam int unsigned AW     = $clog2(LENGTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [AW:0]      req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [1:0]       lc_state,
    input  logic             key_rd_grant,
    input  logic             key_unlock,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic [1:0]       resp_err,
    output logic             mem_rd_en,
    output logic             mem_wr_en,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wrData,
    input  logic [WIDTH-1:0] mem_rdData,
    input  logic             mem_rdData_valid
`ifdef SECMEM_ACCESS_LOG_EN
    ,
    output logic [7:0]       viol_count,
    output logic [AW:0]      viol_last_addr
`endif
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] LEN_A   = (AW+1)'(LENGTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_DENIED  = 2'b01;
    localparam logic [1:0] ERR_RANGE   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WRITE,
        S_READ,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [AW:0]      addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             write_q, write_d;
    logic [1:0]       lc_q, lc_d;
    logic             grd_q, grd_d;
    logic             unl_q, unl_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]       err_q, err_d;

    logic range_err;
    logic deny;
    logic viol;

    // Policy decision on the request captured at accept time.
    always_comb begin
        range_err = (addr_q >= LEN_A);
        deny      = 1'b0;
        if (addr_q[AW:3] == '0) begin
            unique case (addr_q[2:0])
                3'd0, 3'd1: deny = write_q;
                3'd2, 3'd3: deny = write_q ? !unl_q : !grd_q;
                default:    deny = write_q && (addr_q[1:0] != lc_q);
            endcase
        end
    end

    assign viol = (state_q == S_CHECK) && (range_err || deny);

    // Next-state and datapath update for the request/response sequence.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        lc_d    = lc_q;
        grd_d   = grd_q;
        unl_d   = unl_q;
        tmo_d   = tmo_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    lc_d    = lc_state;
                    grd_d   = key_rd_grant;
                    unl_d   = key_unlock;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                rdata_d = '0;
                tmo_d   = '0;
                if (range_err) begin
                    err_d   = ERR_RANGE;
                    state_d = S_RESP;
                end else if (deny) begin
                    err_d   = ERR_DENIED;
                    state_d = S_RESP;
                end else begin
                    err_d   = ERR_OK;
                    state_d = write_q ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                state_d = S_RESP;
            end
            S_READ: begin
                // Valid data wins over a timeout expiring on the same edge.
                if (mem_rdData_valid) begin
                    rdata_d = mem_rdData;
                    state_d = S_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    rdata_d = '0;
                    err_d   = ERR_TIMEOUT;
                    state_d = S_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    rdata_d = '0;
                    err_d   = ERR_OK;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Captured request, timeout counter and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            lc_q    <= '0;
            grd_q   <= 1'b0;
            unl_q   <= 1'b0;
            tmo_q   <= '0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            lc_q    <= lc_d;
            grd_q   <= grd_d;
            unl_q   <= unl_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_rd_en  = (state_q == S_READ);
    assign mem_wr_en  = (state_q == S_WRITE);
    assign mem_addr   = (mem_rd_en || mem_wr_en) ? addr_q[AW-1:0] : '0;
    assign mem_wrData = mem_wr_en ? wdata_q : '0;

`ifdef SECMEM_ACCESS_LOG_EN
    logic [7:0]  viol_cnt_q;
    logic [AW:0] viol_addr_q;

    // Saturating count and last address of denied or out-of-range requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_cnt_q  <= '0;
            viol_addr_q <= '0;
        end else if (viol) begin
            if (viol_cnt_q != 8'hFF) viol_cnt_q <= viol_cnt_q + 8'd1;
            viol_addr_q <= addr_q;
        end
    end

    assign viol_count     = viol_cnt_q;
    assign viol_last_addr = viol_addr_q;
`else
    logic unused_viol;
    assign unused_viol = viol;
`endif

endmodule

// File: tb/tb_secure_mem_access_ctrl.sv
// Self-checking bench for secure_mem_access_ctrl: directed table, corner-case
// sequences (timeout, back-pressure, mid-read reset) and randomized requests
// checked against a rule-level reference model. Honours SECMEM_ACCESS_LOG_EN.
module tb_secure_mem_access_ctrl;
    localparam int unsigned W  = 64;
    localparam int unsigned L  = 16;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW:0]   req_addr = '0;
    logic [W-1:0]  req_wdata = '0;
    logic [1:0]    lc_state = '0;
    logic          key_rd_grant = 1'b0;
    logic          key_unlock = 1'b0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [W-1:0]  resp_rdata;
    logic [1:0]    resp_err;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wrData;
    logic [W-1:0]  mem_rdData = '0;
    logic          mem_rdData_valid = 1'b0;
`ifdef SECMEM_ACCESS_LOG_EN
    logic [7:0]    viol_count;
    logic [AW:0]   viol_last_addr;
    int unsigned   m_viol_n = 0;
    int unsigned   m_viol_a = 0;
`endif

    secure_mem_access_ctrl #(.WIDTH(W), .LENGTH(L), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .lc_state(lc_state),
        .key_rd_grant(key_rd_grant), .key_unlock(key_unlock),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wrData(mem_wrData), .mem_rdData(mem_rdData),
        .mem_rdData_valid(mem_rdData_valid)
`ifdef SECMEM_ACCESS_LOG_EN
        , .viol_count(viol_count), .viol_last_addr(viol_last_addr)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Secure memory stand-in: registered read with configurable latency.
    logic [W-1:0] mem [L];
    logic [W-1:0] ref_mem [L];
    int unsigned  mem_lat = 1;
    bit           mem_stall = 1'b0;
    int unsigned  rd_run = 0;

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wrData;
        if (mem_rd_en) begin
            rd_run           <= rd_run + 1;
            mem_rdData_valid <= !mem_rdData_valid && !mem_stall && (rd_run + 1 == mem_lat);
            mem_rdData       <= mem[mem_addr];
        end else begin
            rd_run           <= 0;
            mem_rdData_valid <= 1'b0;
        end
    end

    function automatic logic [W-1:0] mem_init(int unsigned i);
        logic [31:0] w;
        w = 32'h431909d9 + i - 32'd4;
        return {W/32{w}};
    endfunction

    // Access rules stated directly as address ranges.
    function automatic logic [1:0] model_err(bit wr, int unsigned a, int unsigned lc,
                                             bit grd, bit unl);
        if (a >= L) return 2'b10;
        if (a < 2)  return wr ? 2'b01 : 2'b00;
        if (a < 4)  return (wr ? unl : grd) ? 2'b00 : 2'b01;
        if (a < 8)  return (!wr || (a - 4 == lc)) ? 2'b00 : 2'b01;
        return 2'b00;
    endfunction

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request end to end, with protocol checks along the way.
    task automatic run_req(string name, bit wr, int unsigned a, logic [W-1:0] wd,
                           int unsigned lc, bit grd, bit unl, int unsigned lat,
                           bit stall, int unsigned hold, logic [1:0] exp_err,
                           logic [W-1:0] exp_data, int unsigned exp_lat);
        int unsigned n, edges, rdc, wrc, proto, unstable;
        logic [AW-1:0] ma;
        logic [W-1:0]  held;
        ma        = a[AW-1:0];
        mem_lat   = lat;
        mem_stall = stall;
        resp_ready = (hold == 0);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a[AW:0]; req_wdata = wd;
        lc_state = lc[1:0]; key_rd_grant = grd; key_unlock = unl;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        check({name, "/ready"}, W'(req_ready), W'(1));
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lc_state = ~lc_state; key_rd_grant = ~key_rd_grant; key_unlock = ~key_unlock;
        req_addr = 5'($urandom);
        edges = 1; rdc = 0; wrc = 0; proto = 0;
        while (!resp_valid && edges < 60) begin
            if (mem_rd_en) begin rdc++; if (mem_addr != ma) proto++; end
            if (mem_wr_en) begin
                wrc++;
                if (mem_addr != ma || mem_wrData != wd) proto++;
            end
            if (mem_rd_en && mem_wr_en) proto++;
            if (req_ready) proto++;
            @(negedge clk);
            edges++;
        end
        check({name, "/err"},  W'(resp_err), W'(exp_err));
        check({name, "/data"}, resp_rdata, exp_data);
        check({name, "/lat"},  W'(edges), W'(exp_lat));
        check({name, "/proto"}, W'(proto), W'(0));
        check({name, "/wr_cycles"}, W'(wrc), W'((wr && exp_err == 2'b00) ? 1 : 0));
        if (exp_err == 2'b11)
            check({name, "/rd_cycles"}, W'(rdc), W'(16));
        else if (exp_err != 2'b00 || wr)
            check({name, "/rd_cycles"}, W'(rdc), W'(0));
        else
            check({name, "/rd_seen"}, W'(rdc > 0), W'(1));
        if (hold > 0) begin
            held = resp_rdata;
            unstable = 0;
            for (int unsigned h = 0; h < hold; h++) begin
                @(negedge clk);
                if (!resp_valid || resp_rdata != held || resp_err != exp_err || req_ready)
                    unstable++;
            end
            check({name, "/hold"}, W'(unstable), W'(0));
            resp_ready = 1'b1;
        end
        @(negedge clk);
        check({name, "/post_hs"}, W'({resp_valid, req_ready}), W'(2'b01));
        check({name, "/post_data"}, resp_rdata, '0);
        if (wr && exp_err == 2'b00) ref_mem[a] = wd;
`ifdef SECMEM_ACCESS_LOG_EN
        if (exp_err == 2'b01 || exp_err == 2'b10) begin
            if (m_viol_n < 255) m_viol_n++;
            m_viol_a = a;
        end
        check({name, "/viol_count"}, W'(viol_count), W'(m_viol_n));
        check({name, "/viol_addr"},  W'(viol_last_addr), W'(m_viol_a));
`endif
    endtask

    typedef struct {
        bit           wr;
        int unsigned  a;
        logic [W-1:0] wd;
        int unsigned  lc;
        bit           grd;
        bit           unl;
        logic [1:0]   err;
        logic [W-1:0] rd;
        int unsigned  lat;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int unsigned stale;
        for (int unsigned i = 0; i < L; i++) begin
            mem[i] = mem_init(i);
            ref_mem[i] = mem_init(i);
        end

        tbl[0]  = '{0, 4,  '0,           0, 0, 0, 2'b00, mem_init(4), 4};
        tbl[1]  = '{1, 2,  '1,           0, 1, 0, 2'b01, '0,          2};
        tbl[2]  = '{1, 5,  {8{8'hA5}},   1, 0, 0, 2'b00, '0,          3};
        tbl[3]  = '{0, 5,  '0,           2, 0, 0, 2'b00, {8{8'hA5}},  4};
        tbl[4]  = '{0, 16, '0,           0, 1, 1, 2'b10, '0,          2};
        tbl[5]  = '{1, 0,  '1,           0, 1, 1, 2'b01, '0,          2};
        tbl[6]  = '{0, 2,  '0,           0, 0, 1, 2'b01, '0,          2};
        tbl[7]  = '{0, 2,  '0,           3, 1, 0, 2'b00, mem_init(2), 4};
        tbl[8]  = '{1, 3,  64'h1234,     0, 0, 1, 2'b00, '0,          3};
        tbl[9]  = '{0, 3,  '0,           0, 1, 0, 2'b00, 64'h1234,    4};
        tbl[10] = '{1, 6,  '1,           1, 0, 0, 2'b01, '0,          2};
        tbl[11] = '{1, 7,  64'h77,       3, 0, 0, 2'b00, '0,          3};
        tbl[12] = '{0, 1,  '0,           0, 0, 0, 2'b00, mem_init(1), 4};
        tbl[13] = '{1, 31, '1,           0, 1, 1, 2'b10, '0,          2};

        repeat (3) @(negedge clk);
        check("rst/req_ready",  W'(req_ready),  W'(1));
        check("rst/resp_valid", W'(resp_valid), W'(0));
        check("rst/resp_rdata", resp_rdata,     '0);
        check("rst/resp_err",   W'(resp_err),   W'(0));
        check("rst/mem_en",     W'({mem_rd_en, mem_wr_en}), W'(0));
        check("rst/mem_addr",   W'(mem_addr),   W'(0));
        check("rst/mem_wrData", mem_wrData,     '0);
        rst_n = 1'b1;

        for (int unsigned i = 0; i < 14; i++)
            run_req($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].lc,
                    tbl[i].grd, tbl[i].unl, 1, 1'b0, 0, tbl[i].err, tbl[i].rd, tbl[i].lat);

        // Memory never answers: read must time out after 16 rd_en cycles.
        run_req("timeout", 0, 8, '0, 0, 0, 0, 1, 1'b1, 0, 2'b11, '0, 18);
        // Back-pressure on the response channel.
        run_req("hold5", 0, 4, '0, 0, 0, 0, 1, 1'b0, 5, 2'b00, mem_init(4), 4);
        run_req("after_hold", 0, 9, '0, 0, 0, 0, 2, 1'b0, 0, 2'b00, ref_mem[9], 5);

        // Reset asserted while a read is outstanding.
        mem_stall = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd8;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst/in_read", W'(mem_rd_en), W'(1));
        rst_n = 1'b0;
        #1;
        check("midrst/now", W'({mem_rd_en, resp_valid, req_ready}), W'(3'b001));
        @(negedge clk);
        rst_n = 1'b1;
        mem_stall = 1'b0;
`ifdef SECMEM_ACCESS_LOG_EN
        m_viol_n = 0;
        m_viol_a = 0;
`endif
        stale = 0;
        repeat (20) begin
            @(negedge clk);
            if (resp_valid || mem_rd_en || !req_ready) stale++;
        end
        check("midrst/stale", W'(stale), W'(0));

        // Randomized requests against the rule-level model.
        for (int unsigned k = 0; k < 120; k++) begin
            bit           wr, grd, unl;
            int unsigned  a, lc, lat, hold;
            logic [W-1:0] wd, ed;
            logic [1:0]   ee;
            int unsigned  el;
            wr   = 1'($urandom);
            a    = $urandom_range(0, 2*L - 1);
            lc   = $urandom_range(0, 3);
            grd  = 1'($urandom);
            unl  = 1'($urandom);
            lat  = $urandom_range(1, 4);
            hold = $urandom_range(0, 2);
            wd   = {$urandom, $urandom};
            ee   = model_err(wr, a, lc, grd, unl);
            ed   = (ee == 2'b00 && !wr) ? ref_mem[a] : '0;
            el   = (ee != 2'b00) ? 2 : (wr ? 3 : 3 + lat);
            run_req($sformatf("rnd%0d", k), wr, a, wd, lc, grd, unl, lat, 1'b0,
                    hold, ee, ed, el);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
